retire_stage: RTL and testbench

RETIRE_STAGE -- requirements
Module: retire_stage

---
 rtl/retire_stage_pkg.sv | 8 +
 rtl/retire_stage_arch_map_table.sv | 22 ++
 rtl/sys_defs.svh | 17 +
 rtl/retire_stage.sv | 98 +++++++++
 tb/tb_retire_stage.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/retire_stage_pkg.sv
// retire_stage_pkg: retire slot/arch-reg counts and a 3-bit popcount helper
package retire_stage_pkg;
  localparam int NUM_SLOTS = 3;
  localparam int ARCH_REGS = 32;
  function automatic logic [1:0] count3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction
endpackage

// File: rtl/retire_stage_arch_map_table.sv
// arch_map_table: 32-entry arch map, 3 write ports (port 0 youngest wins), identity on reset; ports clock, reset, i_we/i_addr/i_data per port, o_map full vector
`include "sys_defs.svh"
module arch_map_table
  import retire_stage_pkg::*;
(
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_SLOTS-1:0]                 i_we,
  input  logic [NUM_SLOTS-1:0][4:0]            i_addr,
  input  logic [NUM_SLOTS-1:0][`PRW-1:0]       i_data,
  output logic [ARCH_REGS-1:0][`PRW-1:0]       o_map
);
  logic [ARCH_REGS-1:0][`PRW-1:0] r_map;
  assign o_map = r_map;
  // ports applied oldest to youngest so the youngest write lands last; entry 0 is never written
  always_ff @(posedge clock)
    if (reset)
      for (int r = 0; r < ARCH_REGS; r++) r_map[r] <= r[`PRW-1:0];
    else
      for (int i = NUM_SLOTS - 1; i >= 0; i--)
        if (i_we[i] && i_addr[i] != 5'd0) r_map[i_addr[i]] <= i_data[i];
endmodule

// File: rtl/sys_defs.svh
// sys_defs: shared widths and the ROB retire packet
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH
`define XLEN 32
`define PRW 6
`define SD
typedef struct packed {
  logic              valid;
  logic [4:0]        arch_reg;
  logic [`PRW-1:0]   Tnew;
  logic [`PRW-1:0]   Told;
  logic              is_store;
  logic              halt;
  logic              precise_state_need;
  logic [`XLEN-1:0]  target_pc;
} ROB_ENTRY_PACKET;
`endif

// File: rtl/retire_stage.sv
// retire_stage: 3-wide in-order commit with flush/halt squash; ports clock, reset, retire_entry in; fl_free_valid/fl_free_reg, arch_map, BPRecoverEN/recover_pc, sq_retire_num, halted out; RETIRE_STATS_EN adds retired_count/mispredict_count/cycle_count
`include "sys_defs.svh"
module retire_stage
  import retire_stage_pkg::*;
(
  input  logic                                clock,
  input  logic                                reset,
  input  ROB_ENTRY_PACKET [NUM_SLOTS-1:0]     retire_entry,
  output logic [NUM_SLOTS-1:0]                fl_free_valid,
  output logic [NUM_SLOTS-1:0][`PRW-1:0]      fl_free_reg,
  output logic [ARCH_REGS-1:0][`PRW-1:0]      arch_map,
  output logic                                BPRecoverEN,
  output logic [`XLEN-1:0]                    recover_pc,
  output logic [1:0]                          sq_retire_num,
  output logic                                halted
`ifdef RETIRE_STATS_EN
  ,
  output logic [31:0]                         retired_count,
  output logic [31:0]                         mispredict_count,
  output logic [31:0]                         cycle_count
`endif
);
  typedef enum logic {RUN, HALTED} state_e;
  state_e r_state, w_next;
  logic [NUM_SLOTS-1:0] w_commit, w_we, w_mis, w_halt, w_store;
  logic [NUM_SLOTS-1:0][4:0] w_addr;
  logic [NUM_SLOTS-1:0][`PRW-1:0] w_tnew;
  logic w_blk;
  logic [NUM_SLOTS-1:0] r_free_valid;
  logic [NUM_SLOTS-1:0][`PRW-1:0] r_free_reg;
  // a committing halt or mispredict blocks every younger slot in the same cycle
  always_comb begin
    w_blk = 1'b0;
    w_commit = '0;
    w_we = '0;
    w_mis = '0;
    w_halt = '0;
    w_store = '0;
    w_addr = '0;
    w_tnew = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      w_commit[i] = (r_state == RUN) && retire_entry[i].valid && !w_blk;
      w_halt[i] = w_commit[i] && retire_entry[i].halt;
      w_mis[i] = w_commit[i] && retire_entry[i].precise_state_need && !retire_entry[i].halt;
      w_store[i] = w_commit[i] && retire_entry[i].is_store;
      w_we[i] = w_commit[i] && retire_entry[i].arch_reg != 5'd0;
      w_addr[i] = retire_entry[i].arch_reg;
      w_tnew[i] = retire_entry[i].Tnew;
      w_blk = w_blk || w_halt[i] || w_mis[i];
    end
  end
  always_comb begin
    w_next = r_state;
    if (r_state == RUN && |w_halt) w_next = HALTED;
  end
  always_ff @(posedge clock)
    r_state <= reset ? RUN : w_next;
  always_ff @(posedge clock)
    if (reset) begin
      r_free_valid <= '0;
      r_free_reg <= '0;
    end else begin
      r_free_valid <= w_we;
      for (int i = 0; i < NUM_SLOTS; i++) r_free_reg[i] <= w_we[i] ? retire_entry[i].Told : '0;
    end
  arch_map_table u_map (
    .clock  (clock),
    .reset  (reset),
    .i_we   (w_we),
    .i_addr (w_addr),
    .i_data (w_tnew),
    .o_map  (arch_map)
  );
  assign fl_free_valid = r_free_valid;
  assign fl_free_reg = r_free_reg;
  assign halted = r_state == HALTED;
  assign BPRecoverEN = |w_mis;
  assign recover_pc = w_mis[2] ? retire_entry[2].target_pc :
                      w_mis[1] ? retire_entry[1].target_pc :
                      w_mis[0] ? retire_entry[0].target_pc : '0;
  assign sq_retire_num = count3(w_store);
`ifdef RETIRE_STATS_EN
  logic [31:0] r_retired, r_mispredict, r_cycles;
  always_ff @(posedge clock)
    if (reset) begin
      r_retired <= '0;
      r_mispredict <= '0;
      r_cycles <= '0;
    end else if (r_state == RUN) begin
      r_retired <= r_retired + {30'd0, count3(w_commit)};
      r_mispredict <= r_mispredict + {31'd0, BPRecoverEN};
      r_cycles <= r_cycles + 32'd1;
    end
  assign retired_count = r_retired;
  assign mispredict_count = r_mispredict;
  assign cycle_count = r_cycles;
`endif
endmodule

// File: tb/tb_retire_stage.sv
// tb_retire_stage: directed vectors with a queue scoreboard checked by a negedge monitor
`include "sys_defs.svh"
module tb_retire_stage;
  logic clock = 1'b0;
  logic reset;
  ROB_ENTRY_PACKET [2:0] retire_entry;
  logic [2:0] fl_free_valid;
  logic [2:0][`PRW-1:0] fl_free_reg;
  logic [31:0][`PRW-1:0] arch_map;
  logic BPRecoverEN;
  logic [`XLEN-1:0] recover_pc;
  logic [1:0] sq_retire_num;
  logic halted;
  always #5 clock = ~clock;
  retire_stage dut (
    .clock         (clock),
    .reset         (reset),
    .retire_entry  (retire_entry),
    .fl_free_valid (fl_free_valid),
    .fl_free_reg   (fl_free_reg),
    .arch_map      (arch_map),
    .BPRecoverEN   (BPRecoverEN),
    .recover_pc    (recover_pc),
    .sq_retire_num (sq_retire_num),
    .halted        (halted)
  );
  typedef struct {
    int s;
    logic bp;
    logic [31:0] pc;
    logic [1:0] sq;
    logic [2:0] fv;
    logic [2:0][`PRW-1:0] fr;
    logic h;
    logic [31:0][`PRW-1:0] map;
  } rec_t;
  rec_t q[$];
  int checks = 0;
  int errors = 0;
  int step_no = 0;
  logic [31:0][`PRW-1:0] em;
  ROB_ENTRY_PACKET z;
  task automatic chk(input string n, input int s, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", n, s, got, exp);
    end
  endtask
  always @(negedge clock)
    if (q.size() > 0) begin
      rec_t r;
      r = q.pop_front();
      chk("BPRecoverEN", r.s, 192'(BPRecoverEN), 192'(r.bp));
      chk("recover_pc", r.s, 192'(recover_pc), 192'(r.pc));
      chk("sq_retire_num", r.s, 192'(sq_retire_num), 192'(r.sq));
      chk("fl_free_valid", r.s, 192'(fl_free_valid), 192'(r.fv));
      chk("fl_free_reg", r.s, 192'(fl_free_reg), 192'(r.fr));
      chk("halted", r.s, 192'(halted), 192'(r.h));
      chk("arch_map", r.s, 192'(arch_map), 192'(r.map));
    end
  function automatic ROB_ENTRY_PACKET ent(input logic v, input logic [4:0] ar, input logic [`PRW-1:0] tn,
      input logic [`PRW-1:0] to, input logic st, input logic ht, input logic ps, input logic [31:0] pc);
    ROB_ENTRY_PACKET e;
    e.valid = v;
    e.arch_reg = ar;
    e.Tnew = tn;
    e.Told = to;
    e.is_store = st;
    e.halt = ht;
    e.precise_state_need = ps;
    e.target_pc = pc;
    return e;
  endfunction
  task automatic ident();
    for (int r = 0; r < 32; r++) em[r] = r[`PRW-1:0];
  endtask
  task automatic step(input logic rst, input ROB_ENTRY_PACKET e2, input ROB_ENTRY_PACKET e1, input ROB_ENTRY_PACKET e0,
      input logic bp, input logic [31:0] pc, input logic [1:0] sq, input logic [2:0] fv,
      input logic [`PRW-1:0] f2, input logic [`PRW-1:0] f1, input logic [`PRW-1:0] f0, input logic h);
    rec_t r;
    step_no++;
    reset = rst;
    retire_entry = {e2, e1, e0};
    r.s = step_no;
    r.bp = bp;
    r.pc = pc;
    r.sq = sq;
    r.fv = fv;
    r.fr = {f2, f1, f0};
    r.h = h;
    r.map = em;
    q.push_back(r);
    @(posedge clock);
    #1;
  endtask
  initial begin
    z = '0;
    reset = 1'b1;
    retire_entry = '0;
    ident();
    @(posedge clock);
    #1;
    step(1, z, z, z, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    step(0, ent(1, 5, 40, 10, 0, 0, 0, 0), ent(1, 6, 41, 11, 0, 0, 0, 0), ent(1, 7, 42, 12, 0, 0, 0, 0),
         0, 0, 0, 3'b000, 0, 0, 0, 0);
    em[5] = 40; em[6] = 41; em[7] = 42;
    step(0, z, z, z, 0, 0, 0, 3'b111, 10, 11, 12, 0);
    step(0, ent(1, 8, 43, 13, 0, 0, 1, 32'h1040), ent(1, 9, 44, 14, 0, 0, 0, 0), ent(1, 10, 45, 15, 1, 0, 0, 0),
         1, 32'h1040, 0, 3'b000, 0, 0, 0, 0);
    em[8] = 43;
    step(0, ent(1, 3, 50, 20, 0, 0, 0, 0), z, ent(1, 3, 51, 21, 0, 0, 0, 0),
         0, 0, 0, 3'b100, 13, 0, 0, 0);
    em[3] = 51;
    step(0, ent(1, 11, 52, 22, 1, 0, 0, 0), ent(1, 12, 53, 23, 1, 0, 0, 0), ent(1, 0, 54, 24, 0, 0, 0, 0),
         0, 0, 2, 3'b101, 20, 0, 21, 0);
    em[11] = 52; em[12] = 53;
    step(0, ent(1, 14, 56, 26, 1, 0, 0, 0), ent(1, 15, 57, 27, 0, 1, 1, 32'h3000), ent(1, 16, 58, 28, 1, 0, 0, 0),
         0, 0, 1, 3'b110, 22, 23, 0, 0);
    em[14] = 56; em[15] = 57;
    step(0, ent(1, 17, 60, 30, 1, 0, 1, 32'h4000), ent(1, 18, 61, 31, 0, 0, 0, 0), z,
         0, 0, 0, 3'b110, 26, 27, 0, 1);
    step(0, ent(1, 17, 60, 30, 1, 0, 1, 32'h4000), ent(1, 18, 61, 31, 0, 0, 0, 0), z,
         0, 0, 0, 3'b000, 0, 0, 0, 1);
    step(1, ent(1, 17, 60, 30, 1, 0, 1, 32'h4000), ent(1, 18, 61, 31, 0, 0, 0, 0), z,
         0, 0, 0, 3'b000, 0, 0, 0, 1);
    ident();
    step(0, z, z, z, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    step(1, ent(1, 5, 61, 31, 0, 0, 0, 0), z, z, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    step(0, z, z, z, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    step(0, z, z, z, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
